// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word read at a time, pushes returned words into the queue.
// Push is combinational in the response cycle; SIG_FULL parks the word in a hold buffer until space frees.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        SIG_CLK,
   input  logic        SIG_RSTn,
   input  logic        CMD_REDIRECT,
   input  logic [63:0] DATA_REDIRECT_PC,
   output logic        MEM_REQ_VALID,
   output logic [63:0] MEM_REQ_ADDR,
   input  logic        MEM_REQ_READY,
   input  logic        MEM_RESP_VALID,
   input  logic [31:0] MEM_RESP_DATA,
   output logic        CMD_PUSH,
   output logic [31:0] DATA_TO_PUSH,
   input  logic        SIG_FULL,
   output logic [63:0] DATA_PC
);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
      S_HOLD    = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [63:0] redirect_pc;
   logic [63:0] pc_step;

   assign redirect_pc = DATA_REDIRECT_PC & ~64'h3;
   assign pc_step     = 64'(PC_STEP);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      case (state_q)
         S_REQ: begin
            if (CMD_REDIRECT) begin
               pc_d = redirect_pc;
               if (MEM_REQ_READY) state_d = S_DISCARD;
            end else if (MEM_REQ_READY) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (CMD_REDIRECT) begin
               pc_d    = redirect_pc;
               state_d = MEM_RESP_VALID ? S_REQ : S_DISCARD;
            end else if (MEM_RESP_VALID) begin
               if (SIG_FULL) begin
                  hold_d  = MEM_RESP_DATA;
                  state_d = S_HOLD;
               end else begin
                  pc_d    = pc_q + pc_step;
                  state_d = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (CMD_REDIRECT) begin
               pc_d    = redirect_pc;
               state_d = S_REQ;
            end else if (!SIG_FULL) begin
               pc_d    = pc_q + pc_step;
               state_d = S_REQ;
            end
         end
         default: begin
            // The owed response retires the discard even if a redirect lands in the same cycle.
            if (CMD_REDIRECT) pc_d = redirect_pc;
            if (MEM_RESP_VALID) state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge SIG_CLK) begin
      if (!SIG_RSTn) begin
         // A response still owed from a request issued before reset must not be taken as new data.
         state_q <= ((state_q == S_WAIT || state_q == S_DISCARD) && !MEM_RESP_VALID) ? S_DISCARD : S_REQ;
         pc_q    <= RESET_PC;
         hold_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      MEM_REQ_VALID = SIG_RSTn && (state_q == S_REQ);
      MEM_REQ_ADDR  = pc_q;
      DATA_PC       = pc_q;
      CMD_PUSH      = SIG_RSTn && !CMD_REDIRECT && !SIG_FULL &&
                      (((state_q == S_WAIT) && MEM_RESP_VALID) || (state_q == S_HOLD));
      DATA_TO_PUSH  = 32'h0;
      if (CMD_PUSH) DATA_TO_PUSH = (state_q == S_HOLD) ? hold_q : MEM_RESP_DATA;
   end

endmodule
